// File: rtl/rx_tlp_trigger_gen.sv
// Decides when to issue RX DMA TLPs from the committed producer pointer:
// full 16-qword TLPs, a final TLP that closes the huge page, or a partial TLP after an idle timeout.
module rx_tlp_trigger_gen #(
   parameter int BUF_AW    = 9,
   parameter int HP_QWORDS = 262144,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BUF_AW:0]   wr_addr,
   input  logic              hp_ready,
   output logic              trigger_tlp,
   input  logic              trigger_tlp_ack,
   output logic              send_last_tlp,
   output logic              change_huge_page,
   input  logic              change_huge_page_ack,
   output logic [4:0]        qwords_to_send
);

   localparam int PW  = BUF_AW + 1;
   localparam int HPW = $clog2(HP_QWORDS) + 1;
   // Common width for the min() so that no operand is truncated before comparison.
   localparam int MW  = (PW > HPW) ? PW : HPW;
   localparam int CW  = ((MW > 5) ? MW : 5) + 1;

   localparam logic [CW-1:0]  MAX_TLP = CW'(16);
   localparam logic [HPW-1:0] HP_LOAD = HPW'(HP_QWORDS);
   localparam logic [7:0]     TO_VAL  = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      NEED_HP,
      CHG_REQ,
      IDLE,
      TRIG_REQ,
      LAST_REQ
   } state_t;

   state_t          state, state_next;
   logic [PW-1:0]   issue_addr, issue_addr_next;
   logic [HPW-1:0]  hp_left, hp_left_next;
   logic [7:0]      timer, timer_next;
   logic [4:0]      qwords_next;
   logic            trigger_next, last_next, change_next;

   logic [PW-1:0]   avail;
   logic [CW-1:0]   avail_w, left_w, n_w;
   logic            n_nonzero, closes_page, issue_now;

   // Modular subtraction keeps avail correct across the pointer wrap.
   assign avail   = wr_addr - issue_addr;
   assign avail_w = CW'(avail);
   assign left_w  = CW'(hp_left);

   always_comb begin
      n_w = (avail_w < MAX_TLP) ? avail_w : MAX_TLP;
      if (left_w < n_w) begin
         n_w = left_w;
      end
   end

   assign n_nonzero   = (n_w != '0);
   assign closes_page = (n_w == left_w) && n_nonzero;
   assign issue_now   = (n_w == MAX_TLP) || closes_page || ((timer >= TO_VAL) && n_nonzero);

   always_comb begin
      state_next      = state;
      issue_addr_next = issue_addr;
      hp_left_next    = hp_left;
      qwords_next     = qwords_to_send;

      if ((avail == '0) || trigger_tlp_ack || change_huge_page_ack) begin
         timer_next = 8'd0;
      end else if ((state == IDLE) && (timer != 8'hFF)) begin
         timer_next = timer + 8'd1;
      end else begin
         timer_next = timer;
      end

      case (state)
         NEED_HP: begin
            if (hp_ready) begin
               state_next = CHG_REQ;
            end
         end
         CHG_REQ: begin
            if (change_huge_page_ack) begin
               hp_left_next = HP_LOAD;
               state_next   = IDLE;
            end
         end
         IDLE: begin
            if (issue_now) begin
               qwords_next = n_w[4:0];
               state_next  = closes_page ? LAST_REQ : TRIG_REQ;
            end
         end
         TRIG_REQ: begin
            if (trigger_tlp_ack) begin
               issue_addr_next = issue_addr + PW'(qwords_to_send);
               hp_left_next    = hp_left - HPW'(qwords_to_send);
               state_next      = IDLE;
            end
         end
         LAST_REQ: begin
            if (change_huge_page_ack) begin
               issue_addr_next = issue_addr + PW'(qwords_to_send);
               hp_left_next    = '0;
               state_next      = NEED_HP;
            end
         end
         default: begin
            state_next = NEED_HP;
         end
      endcase

      // Request outputs are a pure function of the state they lead to, so they are mutually exclusive.
      trigger_next = (state_next == TRIG_REQ);
      last_next    = (state_next == LAST_REQ);
      change_next  = (state_next == CHG_REQ);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= NEED_HP;
         issue_addr       <= '0;
         hp_left          <= '0;
         timer            <= 8'd0;
         qwords_to_send   <= 5'd0;
         trigger_tlp      <= 1'b0;
         send_last_tlp    <= 1'b0;
         change_huge_page <= 1'b0;
      end else begin
         state            <= state_next;
         issue_addr       <= issue_addr_next;
         hp_left          <= hp_left_next;
         timer            <= timer_next;
         qwords_to_send   <= qwords_next;
         trigger_tlp      <= trigger_next;
         send_last_tlp    <= last_next;
         change_huge_page <= change_next;
      end
   end

endmodule

// File: tb/tb_rx_tlp_trigger_gen.sv
// Bench for rx_tlp_trigger_gen: one default instance and one small instance (16-entry buffer,
// 40-qword page, short timeout), both checked every cycle against a queue-free behavioural model.
module tb_rx_tlp_trigger_gen;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int  aw_p[2]  = '{9, 4};
   int  hpq_p[2] = '{262144, 40};
   int  to_p[2]  = '{255, 20};

   int  wr_i[2];
   bit  hp_r[2];
   bit  tack[2];
   bit  cack[2];

   logic [9:0] wr0;
   logic [4:0] wr1;
   logic       trig0, last0, chg0, trig1, last1, chg1;
   logic [4:0] q0, q1;
   logic       d_trig[2], d_last[2], d_chg[2];
   logic [4:0] d_q[2];

   assign wr0 = 10'(wr_i[0]);
   assign wr1 = 5'(wr_i[1]);
   assign d_trig[0] = trig0;  assign d_trig[1] = trig1;
   assign d_last[0] = last0;  assign d_last[1] = last1;
   assign d_chg[0]  = chg0;   assign d_chg[1]  = chg1;
   assign d_q[0]    = q0;     assign d_q[1]    = q1;

   rx_tlp_trigger_gen u0 (
      .clk(clk), .reset(reset), .wr_addr(wr0), .hp_ready(hp_r[0]),
      .trigger_tlp(trig0), .trigger_tlp_ack(tack[0]), .send_last_tlp(last0),
      .change_huge_page(chg0), .change_huge_page_ack(cack[0]), .qwords_to_send(q0)
   );

   rx_tlp_trigger_gen #(.BUF_AW(4), .HP_QWORDS(40), .TIMEOUT(20)) u1 (
      .clk(clk), .reset(reset), .wr_addr(wr1), .hp_ready(hp_r[1]),
      .trigger_tlp(trig1), .trigger_tlp_ack(tack[1]), .send_last_tlp(last1),
      .change_huge_page(chg1), .change_huge_page_ack(cack[1]), .qwords_to_send(q1)
   );

   int checks = 0;
   int passes = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
   endtask

   // Model phases: 0 waiting for a page, 1 page requested, 2 accumulating, 3 normal TLP pending, 4 last TLP pending
   int m_mode[2], m_issue[2], m_left[2], m_timer[2], m_q[2];

   task automatic model_step(input int i);
      int m, avail, n, tn;
      m     = 1 << (aw_p[i] + 1);
      avail = (wr_i[i] - m_issue[i] + m) % m;
      n     = avail;
      if (n > 16) n = 16;
      if (n > m_left[i]) n = m_left[i];
      if (avail == 0 || tack[i] || cack[i]) tn = 0;
      else if (m_mode[i] == 2) tn = (m_timer[i] < 255) ? m_timer[i] + 1 : 255;
      else tn = m_timer[i];
      case (m_mode[i])
         0: if (hp_r[i]) m_mode[i] = 1;
         1: if (cack[i]) begin m_left[i] = hpq_p[i]; m_mode[i] = 2; end
         2: if (n > 0 && (n == 16 || n == m_left[i] || m_timer[i] >= to_p[i])) begin
               m_q[i]    = n;
               m_mode[i] = (n == m_left[i]) ? 4 : 3;
            end
         3: if (tack[i]) begin
               m_issue[i] = (m_issue[i] + m_q[i]) % m;
               m_left[i]  = m_left[i] - m_q[i];
               m_mode[i]  = 2;
            end
         4: if (cack[i]) begin
               m_issue[i] = (m_issue[i] + m_q[i]) % m;
               m_left[i]  = 0;
               m_mode[i]  = 0;
            end
         default: m_mode[i] = 0;
      endcase
      m_timer[i] = tn;
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_mode[i] = 0; m_issue[i] = 0; m_left[i] = 0; m_timer[i] = 0; m_q[i] = 0;
         end else begin
            model_step(i);
         end
      end
   end

   bit cmp_en = 1'b0;
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("trig%0d", i), int'(d_trig[i]), int'(m_mode[i] == 3));
            chk($sformatf("last%0d", i), int'(d_last[i]), int'(m_mode[i] == 4));
            chk($sformatf("chg%0d", i),  int'(d_chg[i]),  int'(m_mode[i] == 1));
            chk($sformatf("qws%0d", i),  int'(d_q[i]),    m_q[i]);
            chk($sformatf("excl%0d", i), int'(d_trig[i]) + int'(d_last[i]) + int'(d_chg[i]) <= 1 ? 1 : 0, 1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int m, occ, room, inc;
      wr_i = '{0, 0}; hp_r = '{0, 0}; tack = '{0, 0}; cack = '{0, 0};
      reset = 1'b1;
      repeat (2) tick();
      cmp_en = 1'b1;
      chk("rst_trig", int'(trig0), 0);
      chk("rst_chg", int'(chg0), 0);
      chk("rst_q", int'(q0), 0);
      chk("rst_issue", int'(u0.issue_addr), 0);

      // Page handshake right out of reset
      hp_r[0] = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk("chg_first", int'(chg0), 1);
      tick();
      chk("chg_hold", int'(chg0), 1);
      cack[0] = 1'b1;
      tick();
      cack[0] = 1'b0;
      chk("chg_drop", int'(chg0), 0);
      chk("hp_left_load", int'(u0.hp_left), 262144);

      // Burst of 40 qwords: two full TLPs, then an 8-qword TLP after the idle timeout
      wr_i[0] = 40;
      tick();
      chk("full1_trig", int'(trig0), 1);
      chk("full1_q", int'(q0), 16);
      tack[0] = 1'b1; tick(); tack[0] = 1'b0;
      chk("full1_drop", int'(trig0), 0);
      tick();
      chk("full2_trig", int'(trig0), 1);
      chk("full2_q", int'(q0), 16);
      tack[0] = 1'b1; tick(); tack[0] = 1'b0;
      chk("issue_32", int'(u0.issue_addr), 32);
      k = 0;
      while (!trig0 && k < 400) begin tick(); k++; end
      chk("tmo_wait", k, 256);
      chk("tmo_q", int'(q0), 8);
      tack[0] = 1'b1; tick(); tack[0] = 1'b0;

      // Producer keeps writing while a timed-out partial TLP is pending
      wr_i[0] = 45;
      k = 0;
      while (!trig0 && k < 400) begin tick(); k++; end
      chk("part_wait", k, 256);
      chk("part_q", int'(q0), 5);
      wr_i[0] = 70;
      tick(); tick();
      chk("part_hold_trig", int'(trig0), 1);
      chk("part_hold_q", int'(q0), 5);
      tack[0] = 1'b1; tick(); tack[0] = 1'b0;
      tick();
      chk("next_trig", int'(trig0), 1);
      chk("next_q", int'(q0), 16);

      // Reset while a request is in flight
      reset = 1'b1; wr_i[0] = 0; hp_r[0] = 1'b0;
      tick();
      chk("mid_rst_trig", int'(trig0), 0);
      chk("mid_rst_q", int'(q0), 0);
      chk("mid_rst_issue", int'(u0.issue_addr), 0);
      chk("mid_rst_left", int'(u0.hp_left), 0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("no_hp_hold0", int'(chg0) + int'(trig0), 0);
      end

      // Small instance: fill a 40-qword page across the pointer wrap
      hp_r[1] = 1'b1;
      tick();
      chk("s_chg", int'(chg1), 1);
      cack[1] = 1'b1; tick(); cack[1] = 1'b0;
      chk("s_chg_drop", int'(chg1), 0);
      wr_i[1] = 16;
      tick();
      chk("s_t1", int'(trig1), 1);
      chk("s_t1_q", int'(q1), 16);
      tack[1] = 1'b1; tick(); tack[1] = 1'b0;
      wr_i[1] = 0;
      tick();
      chk("s_wrap_trig", int'(trig1), 1);
      chk("s_wrap_q", int'(q1), 16);
      tack[1] = 1'b1; tick(); tack[1] = 1'b0;
      chk("s_wrap_issue", int'(u1.issue_addr), 0);
      wr_i[1] = 8;
      hp_r[1] = 1'b0;
      tick();
      chk("s_last", int'(last1), 1);
      chk("s_last_q", int'(q1), 8);
      chk("s_last_notrig", int'(trig1), 0);
      cack[1] = 1'b1; tick(); cack[1] = 1'b0;
      chk("s_last_drop", int'(last1), 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("s_no_hp", int'(chg1) + int'(trig1) + int'(last1), 0);
      end
      hp_r[1] = 1'b1;
      tick();
      chk("s_chg_again", int'(chg1), 1);
      cack[1] = 1'b1; tick(); cack[1] = 1'b0;

      // Randomised traffic on both instances, including stray acks
      reset = 1'b1; wr_i = '{0, 0}; hp_r = '{0, 0}; tack = '{0, 0}; cack = '{0, 0};
      tick();
      reset = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 2; i++) begin
            m    = 1 << (aw_p[i] + 1);
            occ  = (wr_i[i] - m_issue[i] + m) % m;
            room = (1 << aw_p[i]) - occ;
            if (room > 0 && ($urandom % 3) == 0) begin
               inc     = $urandom_range(0, (room < 24) ? room : 24);
               wr_i[i] = (wr_i[i] + inc) % m;
            end
            hp_r[i] = (($urandom % 3) != 0);
            tack[i] = (d_trig[i] && ($urandom % 3) == 0) || (($urandom % 25) == 0);
            cack[i] = ((d_chg[i] || d_last[i]) && ($urandom % 3) == 0) || (($urandom % 25) == 0);
         end
         tick();
      end
      tack = '{0, 0}; cack = '{0, 0};
      tick();
      cmp_en = 1'b0;
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
